// File: rtl/ifetch_pkg.sv
// Shared constants and types for the AXI instruction-fetch front end.
package ifetch_pkg;

    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0]  AXI_SIZE_4B     = 3'b010;
    localparam logic [2:0]  AXI_PROT_INSTR  = 3'b100;
    localparam logic [31:0] RV_NOP          = 32'h0000_0013;

    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Show-ahead synchronous FIFO with flush; the head is forced to zero while empty.
module ifetch_queue #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign do_push = push_i && (cnt_q != FULL);
    assign do_pop  = pop_i && (cnt_q != '0);
    assign rdata_o = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/axi_ifetch_unit.sv
// AXI4 single-beat instruction fetcher with a credit-limited prefetch queue and
// redirect handling that discards wrong-path beats still on the bus.
module axi_ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4,
    parameter int          ID_W     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [31:0]     redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [31:0]     pc_o,
    output logic            fetch_err_o,
    output logic            m_arvalid,
    input  logic            m_arready,
    output logic [31:0]     m_araddr,
    output logic [ID_W-1:0] m_arid,
    output logic [7:0]      m_arlen,
    output logic [2:0]      m_arsize,
    output logic [1:0]      m_arburst,
    output logic [2:0]      m_arprot,
    input  logic            m_rvalid,
    output logic            m_rready,
    input  logic [31:0]     m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rlast
);
    localparam int            CW         = $clog2(QDEPTH) + 1;
    localparam logic [CW+1:0] CREDIT_MAX = (CW+2)'(QDEPTH);

    logic          arvalid_q, arvalid_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          stale_ar_q, stale_ar_d;
    logic [CW-1:0] drop_q, drop_d;

    logic          ar_hs, ar_live, ar_stale, r_drop, r_live;
    logic [CW-1:0] pcq_count, fq_count, live_next;
    logic [CW+1:0] credit_used;
    logic [31:0]   pc_head, redirect_base;
    fetch_entry_t  push_entry, head_entry;
    logic          unused_rlast;

    // A stale AR is one still pending when a redirect arrived; it belongs to drop_cnt.
    assign ar_hs         = arvalid_q & m_arready;
    assign ar_live       = ar_hs & ~stale_ar_q;
    assign ar_stale      = ar_hs & stale_ar_q;
    assign r_drop        = m_rvalid & (drop_q != '0);
    assign r_live        = m_rvalid & (drop_q == '0);
    assign redirect_base = align_word(redirect_pc_i);
    assign unused_rlast  = m_rlast;

    // The PC FIFO occupancy is exactly the number of live outstanding ARs.
    ifetch_queue #(.W(32), .DEPTH(QDEPTH)) u_pc_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_i),
        .push_i  (ar_live & ~redirect_i),
        .wdata_i (araddr_q),
        .pop_i   (r_live),
        .rdata_o (pc_head),
        .count_o (pcq_count)
    );

    always_comb begin
        push_entry.err   = (m_rresp != AXI_RESP_OKAY);
        push_entry.pc    = pc_head;
        push_entry.instr = push_entry.err ? RV_NOP : m_rdata;
    end

    ifetch_queue #(.W($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_fetch_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_i),
        .push_i  (r_live & ~redirect_i),
        .wdata_i (push_entry),
        .pop_i   (instr_valid_o & instr_ready_i),
        .rdata_o (head_entry),
        .count_o (fq_count)
    );

    assign instr_valid_o = (fq_count != '0);
    assign instr_o       = head_entry.instr;
    assign pc_o          = head_entry.pc;
    assign fetch_err_o   = head_entry.err;

    assign live_next   = pcq_count + CW'(ar_live) - CW'(r_live);
    assign credit_used = (CW+2)'(pcq_count) + (CW+2)'(fq_count) + (CW+2)'(drop_q);

    always_comb begin
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        fetch_pc_d = fetch_pc_q;
        stale_ar_d = stale_ar_q;
        drop_d     = drop_q - CW'(r_drop) + CW'(ar_stale);
        if (redirect_i) begin
            fetch_pc_d = redirect_base;
            drop_d     = drop_d + live_next;
        end else if (ar_live) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (ar_hs) begin
            arvalid_d  = 1'b0;
            stale_ar_d = 1'b0;
        end else if (arvalid_q) begin
            if (redirect_i) stale_ar_d = 1'b1;
        end else if (credit_used < CREDIT_MAX) begin
            arvalid_d = 1'b1;
            araddr_d  = redirect_i ? redirect_base : fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q  <= 1'b0;
            araddr_q   <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            stale_ar_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            fetch_pc_q <= fetch_pc_d;
            stale_ar_q <= stale_ar_d;
            drop_q     <= drop_d;
        end
    end

    assign m_arvalid = arvalid_q;
    assign m_araddr  = araddr_q;
    assign m_arid    = '0;
    assign m_arlen   = 8'd0;
    assign m_arsize  = AXI_SIZE_4B;
    assign m_arburst = AXI_BURST_INCR;
    assign m_arprot  = AXI_PROT_INSTR;
    assign m_rready  = rst_n;

endmodule
